execute_cc_stage: RTL and testbench

//  Y86-64 execute stage, directly downstream of decode, wrapping the 64-bit add_64 / sub_64 ALU blocks.

---
 rtl/y86_pkg.sv | 39 +++
 rtl/add_64.sv | 8 +
 rtl/cond_eval.sv | 28 ++
 rtl/sub_64.sv | 8 +
 rtl/execute_cc_stage.sv | 150 +++++++++++++++
 tb/tb_execute_cc_stage.sv | 249 ++++++++++++++++++++++++
 6 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode, ALU function and condition encodings shared by the execute stage.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_XOR = 4'd3
    } alu_fn_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } cond_e;

    // Bit positions inside the {ZF,SF,OF} vector
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

// File: rtl/add_64.sv
// rtl/add_64.sv - 64-bit modular adder, o_y = i_a + i_b.
module add_64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_y
);
    assign o_y = i_a + i_b;
endmodule

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch/cmov condition from {ZF,SF,OF} and ifun.
module cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] i_cc,
    input  logic [3:0] i_ifun,
    output logic       o_cnd
);
    logic w_zf;
    logic w_lt;

    assign w_zf = i_cc[CC_ZF];
    assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];

    always_comb begin
        o_cnd = 1'b0;
        case (i_ifun)
            C_ALWAYS: o_cnd = 1'b1;
            C_LE:     o_cnd = w_lt | w_zf;
            C_L:      o_cnd = w_lt;
            C_E:      o_cnd = w_zf;
            C_NE:     o_cnd = !w_zf;
            C_GE:     o_cnd = !w_lt;
            C_G:      o_cnd = !w_lt && !w_zf;
            default:  o_cnd = 1'b0;
        endcase
    end
endmodule

// File: rtl/sub_64.sv
// rtl/sub_64.sv - 64-bit modular subtractor, o_y = i_a - i_b.
module sub_64 (
    input  logic [63:0] i_a,
    input  logic [63:0] i_b,
    output logic [63:0] o_y
);
    assign o_y = i_a - i_b;
endmodule

// File: rtl/execute_cc_stage.sv
// rtl/execute_cc_stage.sv - Y86-64 execute stage with CC ownership and a one-entry result buffer.
// Optional EXEC_STATS_EN adds stat_ops / stat_ovf counters.
module execute_cc_stage
    import y86_pkg::*;
#(
    parameter logic [2:0] CC_RESET = 3'b100
`ifdef EXEC_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] val_a,
    input  logic [63:0] val_b,
    input  logic [63:0] val_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [63:0] val_e,
    output logic        cnd,
    output logic [2:0]  cc
`ifdef EXEC_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_ops,
    output logic [STAT_W-1:0] stat_ovf
`endif
);

    logic        r_out_valid;
    logic [3:0]  r_out_icode;
    logic [63:0] r_val_e;
    logic        r_cnd;
    logic [2:0]  r_cc;

    logic        w_accept;
    logic        w_cc_write;
    logic [63:0] w_alu_a;
    logic [63:0] w_add;
    logic [63:0] w_sub;
    logic [63:0] w_val_e;
    logic        w_of;
    logic        w_cond;
    logic        w_cnd;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_cc_write = w_accept && (icode == I_OPQ) && (ifun <= ALU_XOR);

    // valB is always the left operand; the right operand depends on the instruction class
    always_comb begin
        w_alu_a = 64'd0;
        case (icode)
            I_OPQ:                           w_alu_a = val_a;
            I_RMMOVQ, I_MRMOVQ:              w_alu_a = val_c;
            I_PUSHQ, I_CALL, I_POPQ, I_RET:  w_alu_a = 64'd8;
            default:                         w_alu_a = 64'd0;
        endcase
    end

    add_64 u_add (.i_a(val_b), .i_b(w_alu_a), .o_y(w_add));
    sub_64 u_sub (.i_a(val_b), .i_b(w_alu_a), .o_y(w_sub));

    always_comb begin
        w_val_e = 64'd0;
        w_of    = 1'b0;
        case (icode)
            I_OPQ: begin
                case (ifun)
                    ALU_ADD: begin
                        w_val_e = w_add;
                        w_of    = (val_a[63] == val_b[63]) && (w_add[63] != val_b[63]);
                    end
                    ALU_SUB: begin
                        w_val_e = w_sub;
                        w_of    = (val_a[63] != val_b[63]) && (w_sub[63] != val_b[63]);
                    end
                    ALU_AND: w_val_e = val_a & val_b;
                    ALU_XOR: w_val_e = val_a ^ val_b;
                    default: w_val_e = 64'd0;
                endcase
            end
            I_RRMOVQ:                w_val_e = val_a;
            I_IRMOVQ:                w_val_e = val_c;
            I_RMMOVQ, I_MRMOVQ:      w_val_e = w_add;
            I_PUSHQ, I_CALL:         w_val_e = w_sub;
            I_POPQ, I_RET:           w_val_e = w_add;
            default:                 w_val_e = 64'd0;
        endcase
    end

    // Condition is evaluated against the CC held before this instruction's own update
    cond_eval u_cond (.i_cc(r_cc), .i_ifun(ifun), .o_cnd(w_cond));
    assign w_cnd = w_cond && ((icode == I_RRMOVQ) || (icode == I_JXX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_icode <= I_HALT;
            r_val_e     <= 64'd0;
            r_cnd       <= 1'b0;
            r_cc        <= CC_RESET;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_icode <= icode;
                r_val_e     <= w_val_e;
                r_cnd       <= w_cnd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_cc_write) begin
                r_cc <= {(w_val_e == 64'd0), w_val_e[63], w_of};
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_icode = r_out_icode;
    assign val_e     = r_val_e;
    assign cnd       = r_cnd;
    assign cc        = r_cc;

`ifdef EXEC_STATS_EN
    logic [STAT_W-1:0] r_stat_ops;
    logic [STAT_W-1:0] r_stat_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_ops <= '0;
            r_stat_ovf <= '0;
        end else begin
            if (w_accept) begin
                r_stat_ops <= r_stat_ops + STAT_W'(1);
            end
            if (w_cc_write && w_of) begin
                r_stat_ovf <= r_stat_ovf + STAT_W'(1);
            end
        end
    end

    assign stat_ops = r_stat_ops;
    assign stat_ovf = r_stat_ovf;
`endif

endmodule

// File: tb/tb_execute_cc_stage.sv
// tb/tb_execute_cc_stage.sv - directed self-checking bench for execute_cc_stage.
module tb_execute_cc_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_icode;
    logic [63:0] val_e;
    logic        cnd;
    logic [2:0]  cc;
`ifdef EXEC_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_ovf;
`endif

    int n_checks;
    int n_errors;
    int exp_ops;
    int exp_ovf;

    execute_cc_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .icode     (icode),
        .ifun      (ifun),
        .val_a     (val_a),
        .val_b     (val_b),
        .val_c     (val_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_icode (out_icode),
        .val_e     (val_e),
        .cnd       (cnd),
        .cc        (cc)
`ifdef EXEC_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_ovf  (stat_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one instruction at the falling edge; returns 1ns after the rising edge that accepts it
    task automatic send(input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        icode = ic;
        ifun = fn;
        val_a = a;
        val_b = b;
        val_c = c;
        exp_ops++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ops = 0;
        exp_ovf = 0;
        n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL reset_cc got %b exp %b", cc, 3'b100); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (val_e !== 64'd0) begin n_errors++; $display("FAIL reset_val_e got %h exp 0", val_e); end
        n_checks++; if (cnd !== 1'b0 || out_icode !== 4'h0) begin n_errors++; $display("FAIL reset_cnd_icode got %b/%h exp 0/0", cnd, out_icode); end
    endtask

    task automatic test_sub_overflow();
        send(4'h6, 4'h1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        exp_ovf++;
        n_checks++; if (val_e !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL sub_val_e got %h exp %h", val_e, 64'hFFFF_FFFF_FFFF_FFFF); end
        n_checks++; if (cc !== 3'b011) begin n_errors++; $display("FAIL sub_cc got %b exp 011", cc); end
        n_checks++; if (out_valid !== 1'b1 || out_icode !== 4'h6 || cnd !== 1'b0) begin n_errors++; $display("FAIL sub_meta got v%b i%h c%b exp v1 i6 c0", out_valid, out_icode, cnd); end
    endtask

    task automatic test_add_xor();
        send(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        exp_ovf++;
        n_checks++; if (val_e !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_errors++; $display("FAIL add_val_e got %h exp %h", val_e, 64'hFFFF_FFFF_FFFF_FFFE); end
        n_checks++; if (cc !== 3'b011) begin n_errors++; $display("FAIL add_cc got %b exp 011", cc); end
        send(4'h6, 4'h4, 64'd1, 64'd2, 64'd0);
        n_checks++; if (val_e !== 64'd0) begin n_errors++; $display("FAIL badfn_val_e got %h exp 0", val_e); end
        n_checks++; if (cc !== 3'b011) begin n_errors++; $display("FAIL badfn_cc got %b exp 011", cc); end
        send(4'h6, 4'h3, 64'd5, 64'd5, 64'd0);
        n_checks++; if (val_e !== 64'd0) begin n_errors++; $display("FAIL xor_val_e got %h exp 0", val_e); end
        n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL xor_cc got %b exp 100", cc); end
        send(4'h6, 4'h2, 64'hF0F0, 64'h0FF0, 64'd0);
        n_checks++; if (val_e !== 64'h00F0 || cc !== 3'b000) begin n_errors++; $display("FAIL and_result got %h/%b exp 00f0/000", val_e, cc); end
    endtask

    task automatic test_cond_back_to_back();
        logic [3:0]  ic [0:8];
        logic [3:0]  fn [0:8];
        logic        ecnd [0:8];
        logic [63:0] ev [0:8];
        // 3-5: SF=1, OF=0 -> l true, ge false; then xor 5^5 sets ZF for the trailing je
        send(4'h6, 4'h1, 64'd5, 64'd3, 64'd0);
        n_checks++; if (val_e !== 64'hFFFF_FFFF_FFFF_FFFE || cc !== 3'b010) begin n_errors++; $display("FAIL cond_setup got %h/%b exp fffffffffffffffe/010", val_e, cc); end
        ic = '{4'h7, 4'h7, 4'h7, 4'h2, 4'h2, 4'h3, 4'h7, 4'h6, 4'h7};
        fn = '{4'h2, 4'h5, 4'h0, 4'h3, 4'h6, 4'h0, 4'h7, 4'h3, 4'h3};
        ecnd = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ev = '{64'd0, 64'd0, 64'd0, 64'h1234, 64'h1234, 64'h55, 64'd0, 64'd0, 64'd0};
        for (int i = 0; i < 9; i++) begin
            send(ic[i], fn[i], (ic[i] == 4'h6) ? 64'd5 : 64'h1234, 64'd5, 64'h55);
            n_checks++;
            if (cnd !== ecnd[i] || val_e !== ev[i] || out_icode !== ic[i]) begin
                n_errors++;
                $display("FAIL cond_step%0d got cnd %b val_e %h icode %h exp cnd %b val_e %h icode %h",
                         i, cnd, val_e, out_icode, ecnd[i], ev[i], ic[i]);
            end
        end
    endtask

    task automatic test_addr_modes();
        logic [3:0]  ic [0:7];
        logic [63:0] b [0:7];
        logic [63:0] c [0:7];
        logic [63:0] ev [0:7];
        ic = '{4'h4, 4'h5, 4'hA, 4'h8, 4'hB, 4'h9, 4'h0, 4'h1};
        b  = '{64'h100, 64'h10, 64'h1000, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h77, 64'h77};
        c  = '{64'h20, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h99, 64'h0, 64'h0, 64'h66, 64'h66};
        ev = '{64'h120, 64'h8, 64'hFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1008, 64'h4, 64'h0, 64'h0};
        for (int i = 0; i < 8; i++) begin
            send(ic[i], 4'h0, 64'h3333, b[i], c[i]);
            n_checks++;
            if (val_e !== ev[i] || cnd !== 1'b0) begin
                n_errors++;
                $display("FAIL addr_step%0d got val_e %h cnd %b exp val_e %h cnd 0", i, val_e, cnd, ev[i]);
            end
        end
        n_checks++; if (cc !== 3'b100) begin n_errors++; $display("FAIL addr_cc_kept got %b exp 100", cc); end
    endtask

    task automatic test_stall_release();
        idle();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        icode = 4'h3;
        ifun = 4'h0;
        val_c = 64'hAA;
        exp_ops++;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1 || val_e !== 64'hAA) begin n_errors++; $display("FAIL stall_load got v%b %h exp v1 aa", out_valid, val_e); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            val_c = 64'hBB;
            @(posedge clk);
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || val_e !== 64'hAA || out_icode !== 4'h3) begin
                n_errors++;
                $display("FAIL stall_hold%0d got rdy %b v %b val_e %h exp rdy 0 v 1 val_e aa", k, in_ready, out_valid, val_e);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        exp_ops++;
        @(posedge clk);
        #1;
        n_checks++; if (val_e !== 64'hBB || out_valid !== 1'b1) begin n_errors++; $display("FAIL release_first got %h exp bb", val_e); end
        for (int k = 1; k <= 4; k++) begin
            send(4'h3, 4'h0, 64'd0, 64'd0, 64'hC0 + 64'(k));
            n_checks++;
            if (val_e !== 64'hC0 + 64'(k) || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL release_seq%0d got %h exp %h", k, val_e, 64'hC0 + 64'(k));
            end
        end
        idle();
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL release_drain got v%b exp 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        send(4'h6, 4'h0, 64'd1, 64'd1, 64'd0);
        n_checks++; if (out_valid !== 1'b1 || val_e !== 64'd2 || cc !== 3'b000) begin n_errors++; $display("FAIL pre_reset got v%b %h %b exp v1 2 000", out_valid, val_e, cc); end
`ifdef EXEC_STATS_EN
        n_checks++; if (stat_ops !== 32'(exp_ops)) begin n_errors++; $display("FAIL stat_ops got %0d exp %0d", stat_ops, exp_ops); end
        n_checks++; if (stat_ovf !== 32'(exp_ovf)) begin n_errors++; $display("FAIL stat_ovf got %0d exp %0d", stat_ovf, exp_ovf); end
`endif
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0 || cc !== 3'b100) begin n_errors++; $display("FAIL mid_reset got v%b cc %b exp v0 cc 100", out_valid, cc); end
        n_checks++; if (val_e !== 64'd0 || out_icode !== 4'h0) begin n_errors++; $display("FAIL mid_reset_buf got %h/%h exp 0/0", val_e, out_icode); end
`ifdef EXEC_STATS_EN
        n_checks++; if (stat_ops !== 32'd0 || stat_ovf !== 32'd0) begin n_errors++; $display("FAIL stat_reset got %0d/%0d exp 0/0", stat_ops, stat_ovf); end
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_ops = 0;
        exp_ovf = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        icode = 4'h0;
        ifun = 4'h0;
        val_a = 64'd0;
        val_b = 64'd0;
        val_c = 64'd0;
        test_reset();
        test_sub_overflow();
        test_add_xor();
        test_cond_back_to_back();
        test_addr_modes();
        test_stall_release();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
